dffrs_pipe: RTL and testbench
=============================

DFFRS_PIPE -- requirements
Module: dffrs_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 3, number of register stages (>=1).
REQ-003 SHALL have parameter RST_VAL, default 0, WIDTH-bit value loaded into every stage data register on R.
REQ-004 SHALL have parameter SET_VAL, default all-ones, WIDTH-bit value loaded into every stage data register on S.
REQ-005 SHALL have port clk  input  1  clock, rising-edge active.
REQ-006 SHALL have port R  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port S  input  1  synchronous set/flush, active-high.
REQ-008 SHALL have port in_valid  input  1  upstream data valid.
REQ-009 SHALL have port in_ready  output  1  pipeline can accept D this cycle.
REQ-010 SHALL have port D  input  WIDTH  upstream data.
REQ-011 SHALL have port out_valid  output  1  Q holds valid data.
REQ-012 SHALL have port out_ready  input  1  downstream accepts Q this cycle.
REQ-013 SHALL have port Q  output  WIDTH  last-stage data.
REQ-014 SHALL have port occ  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-015 SHALL implement DEPTH stages, each with a WIDTH-bit data register and a 1-bit valid register; stage 0 takes D, and stage DEPTH-1 drives Q/out_valid.
REQ-016 SHALL advance stage i on a clock edge when stage i is empty or stage i+1 advances, where the last stage advances when out_ready=1 (elastic pipeline, no bubbles required).
REQ-017 SHALL drive in_ready=1 when stage 0 is empty or stage 0 advances, computed combinationally from the downstream ready chain.
REQ-018 SHALL accept D only on a cycle with in_valid=1 and in_ready=1 (input transfer); a stage receiving no valid data SHALL become empty.
REQ-019 SHALL present accepted data at Q with out_valid=1 exactly DEPTH cycles after the input transfer when out_ready stays 1.
REQ-020 SHALL sustain one transfer per cycle with simultaneous input and output transfers when full and out_ready=1.
REQ-021 SHALL hold all stage data and valid registers unchanged while out_ready=0 and the pipeline is full; in_ready SHALL then be 0.
REQ-022 SHALL never drop, duplicate or reorder accepted data.
REQ-023 SHALL, on a clock edge with S=1, load SET_VAL into all data registers and clear all valid registers; in_ready and out_valid SHALL be forced to 0 while S=1.
REQ-024 SHALL give R priority over S, and S priority over any transfer.
REQ-025 SHALL update occ as a registered count: +1 on an input transfer only, -1 on an output transfer only, unchanged on both or neither, 0 after S; range 0..DEPTH.

Reset
REQ-026 SHALL, while R=1 and independent of clk, set all data registers to RST_VAL and clear all valid registers and occ.
REQ-027 SHALL drive Q=RST_VAL, out_valid=0, occ=0, and in_ready=0 while R=1; in_ready SHALL be 1 on the first cycle after R deasserts.
REQ-028 SHALL discard in-flight data when R asserts mid-operation, with no transfers completing in that cycle.

Configuration
REQ-029 SHALL, with macro DFFRS_PIPE_OCC_EN defined, implement the occ counter as per REQ-025.
REQ-030 SHALL, with DFFRS_PIPE_OCC_EN undefined, omit the counter logic and tie occ to 0; all other behaviour SHALL be identical.

Verification
REQ-031 SHALL cover: WIDTH=8, DEPTH=3, R pulse mid-clock -> Q=8'h00, out_valid=0, occ=0 immediately without a clock edge.
REQ-032 SHALL cover: stream D=1,2,3,4 with in_valid=1, out_ready=1 -> Q=1 and out_valid=1 three cycles after the first accept, then 2,3,4 on consecutive cycles.
REQ-033 SHALL cover: out_ready=0 with 5 words offered -> 3 accepted, in_ready=0, occ=3; after out_ready=1, Q=1,2,3 in order, then words 4 and 5 follow.
REQ-034 SHALL cover: S=1 for one cycle with occ=2 -> all data=8'hFF, out_valid=0, occ=0, the input offered during S not accepted.
REQ-035 SHALL cover: R=1 and S=1 together -> data=RST_VAL, not SET_VAL.
REQ-036 SHALL cover: DEPTH=1 build with and without DFFRS_PIPE_OCC_EN -> full-throughput passthrough with 1-cycle latency; occ counts 0/1 only when the macro is defined and stays 0 otherwise.

Source files
------------

// File: rtl/dffrs_pipe.sv
// Elastic DEPTH-stage register pipeline with async reset (R), sync set/flush (S) and valid/ready handshake.
// Define DFFRS_PIPE_OCC_EN to build the registered occupancy counter; otherwise occ is tied to zero.
module dffrs_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL = '1
) (
  input  logic                       clk,
  input  logic                       R,
  input  logic                       S,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           D,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           Q,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  logic [WIDTH-1:0] data_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] adv_s;
  logic             in_fire_s;

  // Ready chain: a stage may load when it is empty or everything ahead of it moves.
  always_comb begin
    adv_s          = '0;
    adv_s[DEPTH-1] = out_ready | ~valid_r[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv_s[i] = ~valid_r[i] | adv_s[i+1];
    end
  end

  assign in_ready  = adv_s[0] & ~S & ~R;
  assign in_fire_s = in_valid & in_ready;
  assign out_valid = valid_r[DEPTH-1] & ~S;
  assign Q         = data_r[DEPTH-1];

  // Stage registers; data only moves with a valid word so idle stages keep their contents.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i]  <= RST_VAL;
        valid_r[i] <= 1'b0;
      end
    end else if (S) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i]  <= SET_VAL;
        valid_r[i] <= 1'b0;
      end
    end else begin
      if (adv_s[0]) begin
        valid_r[0] <= in_fire_s;
        if (in_fire_s) begin
          data_r[0] <= D;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv_s[i]) begin
          valid_r[i] <= valid_r[i-1];
          if (valid_r[i-1]) begin
            data_r[i] <= data_r[i-1];
          end
        end
      end
    end
  end

`ifdef DFFRS_PIPE_OCC_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             out_fire_s;
  logic [OCC_W-1:0] occ_r;

  assign out_fire_s = out_valid & out_ready;

  // Occupancy tracks handshakes at the two ends; simultaneous in/out cancel.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      occ_r <= '0;
    end else if (S) begin
      occ_r <= '0;
    end else if (in_fire_s && !out_fire_s) begin
      occ_r <= occ_r + OCC_W'(1'b1);
    end else if (!in_fire_s && out_fire_s) begin
      occ_r <= occ_r - OCC_W'(1'b1);
    end else begin
      occ_r <= occ_r;
    end
  end

  assign occ = occ_r;
`else
  assign occ = '0;
`endif

endmodule

// File: tb/tb_dffrs_pipe.sv
// Self-checking bench for dffrs_pipe: DEPTH=3 and DEPTH=1 instances against a transaction-level model.
module tb_dffrs_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       R, S, in_valid, out_ready;
  logic [7:0] D;

  logic       ir3, ov3, ir1, ov1;
  logic [7:0] q3, q1;
  logic [1:0] occ3;
  logic [0:0] occ1;

  dffrs_pipe #(.WIDTH(8), .DEPTH(3)) dut3 (
    .clk(clk), .R(R), .S(S), .in_valid(in_valid), .in_ready(ir3), .D(D),
    .out_valid(ov3), .out_ready(out_ready), .Q(q3), .occ(occ3)
  );

  dffrs_pipe #(.WIDTH(8), .DEPTH(1)) dut1 (
    .clk(clk), .R(R), .S(S), .in_valid(in_valid), .in_ready(ir1), .D(D),
    .out_valid(ov1), .out_ready(out_ready), .Q(q1), .occ(occ1)
  );

`ifdef DFFRS_PIPE_OCC_EN
  localparam bit OCC_ON = 1'b1;
`else
  localparam bit OCC_ON = 1'b0;
`endif

  logic        obs_ir  [2];
  logic        obs_ov  [2];
  logic [7:0]  obs_q   [2];
  logic [31:0] obs_occ [2];
  assign obs_ir[0]  = ir3;
  assign obs_ir[1]  = ir1;
  assign obs_ov[0]  = ov3;
  assign obs_ov[1]  = ov1;
  assign obs_q[0]   = q3;
  assign obs_q[1]   = q1;
  assign obs_occ[0] = {30'd0, occ3};
  assign obs_occ[1] = {31'd0, occ1};

  // Model: per instance, an ordered list of accepted words with their accept cycle.
  int         dep [2];
  logic [7:0] md [2][256];
  int         mcyc [2][256];
  int         hd [2];
  int         tl [2];
  int         last_out [2];
  bit         fin [2];
  bit         fout [2];
  int         cyc;
  int         n_assert;
  int         n_fail;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s depth=%0d observed=%0h expected=%0h", tag, dep[k], obs, exp);
    end
  endtask

  // Check one cycle against the model, then clock it and advance the model.
  task automatic tick();
    #1;
    for (int k = 0; k < 2; k++) begin
      int cnt;
      int av;
      bit eir;
      bit eov;
      if (R) hd[k] = tl[k];
      cnt = tl[k] - hd[k];
      // Some stage is free iff fewer than DEPTH words are held.
      eir = !R && !S && (cnt < dep[k] || out_ready);
      eov = 1'b0;
      if (!S && cnt > 0) begin
        // Head word reaches the output DEPTH cycles after accept, but not before its predecessor left.
        av = mcyc[k][hd[k] & 255] + dep[k];
        if (last_out[k] + 1 > av) av = last_out[k] + 1;
        eov = (cyc >= av);
      end
      chk("in_ready", k, 32'(obs_ir[k]), 32'(eir));
      chk("out_valid", k, 32'(obs_ov[k]), 32'(eov));
      chk("occ", k, obs_occ[k], OCC_ON ? 32'(cnt) : 32'd0);
      if (eov) chk("q_data", k, 32'(obs_q[k]), 32'(md[k][hd[k] & 255]));
      if (R) chk("q_reset", k, 32'(obs_q[k]), 32'h0);
      fin[k]  = in_valid && eir;
      fout[k] = eov && out_ready;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (R || S) begin
        hd[k] = tl[k];
      end else begin
        if (fout[k]) begin
          hd[k]++;
          last_out[k] = cyc;
        end
        if (fin[k]) begin
          md[k][tl[k] & 255]   = D;
          mcyc[k][tl[k] & 255] = cyc;
          tl[k]++;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int w;
    dep[0] = 3; dep[1] = 1;
    for (int k = 0; k < 2; k++) begin
      hd[k] = 0; tl[k] = 0; last_out[k] = -100; fin[k] = 1'b0; fout[k] = 1'b0;
    end
    cyc = 0; n_assert = 0; n_fail = 0;
    R = 1'b1; S = 1'b0; in_valid = 1'b0; out_ready = 1'b0; D = 8'h00;
    @(negedge clk);

    // Reset state, then first cycle after release
    tick(); tick();
    R = 1'b0;
    tick();

    // Stream 1..4 at full throughput
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; D = 8'(i); tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();

    // Backpressure: offer five words with out_ready low, then release
    out_ready = 1'b0; w = 1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; D = 8'(w); tick();
      if (fin[0]) w++;
    end
    chk("bp_accepted", 0, 32'(w - 1), 32'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && w <= 5; i++) begin
      in_valid = 1'b1; D = 8'(w); tick();
      if (fin[0]) w++;
    end
    in_valid = 1'b0;
    repeat (5) tick();

    // Synchronous set with two words held, input offered during S
    out_ready = 1'b0; in_valid = 1'b1;
    D = 8'hA1; tick();
    D = 8'hA2; tick();
    S = 1'b1; D = 8'hA3; tick();
    #1;
    chk("set_q", 0, 32'(q3), 32'hFF);
    chk("set_q", 1, 32'(q1), 32'hFF);
    S = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    // Reset asserted between clock edges with data in flight
    out_ready = 1'b0; in_valid = 1'b1; D = 8'h5A;
    tick(); tick();
    in_valid = 1'b0;
    #2 R = 1'b1;
    #1;
    chk("async_q", 0, 32'(q3), 32'h0);
    chk("async_ov", 0, 32'(ov3), 32'h0);
    chk("async_occ", 0, obs_occ[0], 32'h0);
    chk("async_ir", 0, 32'(ir3), 32'h0);
    chk("async_q", 1, 32'(q1), 32'h0);
    tick();
    R = 1'b0; out_ready = 1'b1;
    tick();

    // R and S together: reset value wins
    out_ready = 1'b0; in_valid = 1'b1; D = 8'h33;
    tick(); tick();
    R = 1'b1; S = 1'b1;
    tick();
    chk("rs_q", 0, 32'(q3), 32'h0);
    chk("rs_q", 1, 32'(q1), 32'h0);
    R = 1'b0; S = 1'b0; in_valid = 1'b0;
    tick();

    // Random traffic with occasional flush
    repeat (400) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      S         = ($urandom_range(0, 39) == 0);
      D         = 8'($urandom);
      tick();
    end
    S = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
